// File: rtl/pmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// pmem_arb_pkg
// Shared definitions for the PMEM (output SRAM) arbiter:
//   - requester index constants (OFIFO writeback, SFU RMW, host readout)
//   - default SRAM address / data widths
//   - rr_pick(): round-robin one-hot pick over up to 8 requesters
// ---------------------------------------------------------------------------
package pmem_arb_pkg;

   localparam int REQ_OFIFO   = 0;
   localparam int REQ_SFU     = 1;
   localparam int REQ_HOST    = 2;

   localparam int PMEM_ADDR_W = 9;
   localparam int PMEM_DATA_W = 128;

   // One-hot pick of the first active request at or after ptr, searching
   // n slots. The wrap is done by subtraction so a non-power-of-2 n never
   // indexes past the last requester.
   function automatic logic [7:0] rr_pick(input logic [7:0]  req,
                                          input logic [2:0]  ptr,
                                          input int unsigned n);
      logic [7:0]  pick;
      logic        found;
      int unsigned idx;
      pick  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (i < n && !found) begin
            idx = 32'(ptr) + i;
            if (idx >= n) idx = idx - n;
            if (req[idx[2:0]]) begin
               pick[idx[2:0]] = 1'b1;
               found          = 1'b1;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/pmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// pmem_arbiter_if
// Requester-side bus of the PMEM arbiter.
//   req       [NREQ]         access request per requester
//   req_we    [NREQ]         1 = write, 0 = read
//   req_lock  [NREQ]         keep the grant next cycle (read-modify-write)
//   req_addr  [NREQ*ADDR_W]  requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata [NREQ*DATA_W]  requester i at [i*DATA_W +: DATA_W]
//   gnt       [NREQ]         one-hot grant, access happens this cycle
//   rvalid    [NREQ]         one-hot read data valid, RD_LAT after grant
//   rdata     [DATA_W]       read data
// master = requesters, slave = arbiter.
// ---------------------------------------------------------------------------
interface pmem_arbiter_if #(
   parameter int NREQ   = 3,
   parameter int ADDR_W = 9,
   parameter int DATA_W = 128
);
   logic [NREQ-1:0]        req;
   logic [NREQ-1:0]        req_we;
   logic [NREQ-1:0]        req_lock;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_wdata;
   logic [NREQ-1:0]        gnt;
   logic [NREQ-1:0]        rvalid;
   logic [DATA_W-1:0]      rdata;

   modport master (output req, req_we, req_lock, req_addr, req_wdata,
                   input  gnt, rvalid, rdata);
   modport slave  (input  req, req_we, req_lock, req_addr, req_wdata,
                   output gnt, rvalid, rdata);
endinterface

// File: rtl/pmem_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick.
//   req     [NREQ]   requests
//   ptr     [PTR_W]  requester with highest priority this cycle
//   gnt     [NREQ]   one-hot winner (0 when no request)
//   gnt_idx [PTR_W]  encoded winner (0 when no request)
// ---------------------------------------------------------------------------
module rr_arbiter
   import pmem_arb_pkg::*;
#(
   parameter int NREQ = 3
) (
   input  logic [NREQ-1:0]           req,
   input  logic [$clog2(NREQ)-1:0]   ptr,
   output logic [NREQ-1:0]           gnt,
   output logic [$clog2(NREQ)-1:0]   gnt_idx
);
   localparam int PTR_W = $clog2(NREQ);

   assign gnt = NREQ'(rr_pick(8'(req), 3'(ptr), NREQ));

   // NOTE: every output of a combinational block gets a default before any
   // conditional assignment, otherwise the missing paths infer a latch.
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) gnt_idx = PTR_W'(i);
      end
   end

endmodule

// File: rtl/pmem_arbiter.sv
// ---------------------------------------------------------------------------
// pmem_arbiter
// Shares the single-port PMEM SRAM between NREQ requesters, one access per
// cycle. Priority: active lock owner, then (PMEM_ARB_AGE_EN only) the lowest
// aged requester, then round-robin from ptr. Read grants push the requester
// id into an RD_LAT-deep tag pipe that produces the one-hot rvalid.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   bus          pmem_arbiter_if.slave (req/we/lock/addr/wdata, gnt/rvalid/rdata)
//   OP_q         SRAM read data (passed straight to bus.rdata)
//   OP_d         SRAM write data
//   OP_addr      SRAM address
//   OP_cen       SRAM chip enable, active-low
//   OP_wen       SRAM write enable, active-low
// Build option: define PMEM_ARB_AGE_EN to add per-requester wait counters
// that promote a requester after AGE_LIMIT waiting cycles.
// ---------------------------------------------------------------------------
module pmem_arbiter
   import pmem_arb_pkg::*;
#(
   parameter int NREQ      = 3,
   parameter int ADDR_W    = PMEM_ADDR_W,
   parameter int DATA_W    = PMEM_DATA_W,
   parameter int RD_LAT    = 1,
   parameter int AGE_LIMIT = 15
) (
   input  logic              clk,
   input  logic              reset,
   pmem_arbiter_if.slave     bus,
   input  logic [DATA_W-1:0] OP_q,
   output logic [DATA_W-1:0] OP_d,
   output logic [ADDR_W-1:0] OP_addr,
   output logic              OP_cen,
   output logic              OP_wen
);
   localparam int PTR_W = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 8 || RD_LAT < 1 || AGE_LIMIT < 1) begin : g_bad_param
      $error("pmem_arbiter: NREQ must be 2..8, RD_LAT and AGE_LIMIT >= 1");
   end

   logic [PTR_W-1:0] ptr;
   logic             lock_vld;
   logic [PTR_W-1:0] lock_owner;
   logic             lock_hit;
   logic [NREQ-1:0]  rr_gnt;
   logic [PTR_W-1:0] rr_idx;
   logic [NREQ-1:0]  gnt_oh;
   logic [PTR_W-1:0] gnt_idx;
   logic             any_gnt;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req     (bus.req),
      .ptr     (ptr),
      .gnt     (rr_gnt),
      .gnt_idx (rr_idx)
   );

   // Lock holds only while the owner keeps requesting; once req drops the
   // normal pick takes over in the same cycle.
   assign lock_hit = lock_vld && bus.req[lock_owner];

`ifdef PMEM_ARB_AGE_EN
   localparam int AGE_W = $clog2(AGE_LIMIT + 1);

   logic [AGE_W-1:0] age_cnt [NREQ];
   logic [NREQ-1:0]  aged;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         aged[i] = bus.req[i] && (age_cnt[i] >= AGE_W'(AGE_LIMIT));
      end
   end

   // Counters saturate at AGE_LIMIT so a long lock cannot wrap them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREQ; i++) age_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (!bus.req[i] || gnt_oh[i])              age_cnt[i] <= '0;
            else if (age_cnt[i] < AGE_W'(AGE_LIMIT))   age_cnt[i] <= age_cnt[i] + 1'b1;
         end
      end
   end
`endif

   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      if (reset) begin
         gnt_oh  = '0;
      end else if (lock_hit) begin
         gnt_oh[lock_owner] = 1'b1;
         gnt_idx            = lock_owner;
`ifdef PMEM_ARB_AGE_EN
      end else if (|aged) begin
         for (int i = NREQ - 1; i >= 0; i--) begin
            if (aged[i]) gnt_idx = PTR_W'(i);
         end
         gnt_oh[gnt_idx] = 1'b1;
`endif
      end else begin
         gnt_oh  = rr_gnt;
         gnt_idx = rr_idx;
      end
   end

   assign any_gnt = |gnt_oh;
   assign bus.gnt = gnt_oh;

   // Idle cycles drive zeros rather than the last winner's fields.
   always_comb begin
      OP_cen  = 1'b1;
      OP_wen  = 1'b1;
      OP_addr = '0;
      OP_d    = '0;
      if (any_gnt) begin
         OP_cen  = 1'b0;
         OP_wen  = ~bus.req_we[gnt_idx];
         OP_addr = bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
         OP_d    = bus.req_wdata[gnt_idx*DATA_W +: DATA_W];
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr        <= '0;
         lock_vld   <= 1'b0;
         lock_owner <= '0;
      end else if (any_gnt) begin
         ptr        <= (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
         lock_vld   <= bus.req_lock[gnt_idx];
         lock_owner <= gnt_idx;
      end else begin
         lock_vld   <= 1'b0;
      end
   end

   // Read-return tag pipe: valid bits are reset (flushes in-flight reads),
   // the ids ride alongside.
   logic [RD_LAT-1:0] tag_vld;
   logic [PTR_W-1:0]  tag_id [RD_LAT];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_vld <= '0;
      end else begin
         tag_vld[0] <= any_gnt && !bus.req_we[gnt_idx];
         for (int i = 1; i < RD_LAT; i++) tag_vld[i] <= tag_vld[i-1];
      end
   end

   // NOTE: the id array carries no reset; it is only read when the matching
   // valid bit is set, so clearing it would add reset fan-out for nothing.
   always_ff @(posedge clk) begin
      tag_id[0] <= gnt_idx;
      for (int i = 1; i < RD_LAT; i++) tag_id[i] <= tag_id[i-1];
   end

   always_comb begin
      bus.rvalid = '0;
      if (tag_vld[RD_LAT-1]) bus.rvalid[tag_id[RD_LAT-1]] = 1'b1;
   end

   assign bus.rdata = OP_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pmem_arbiter
// Directed bench for pmem_arbiter (NREQ=3, 9-bit address, 128-bit data,
// RD_LAT=1) with a behavioural single-port SRAM. Inputs change 1 time unit
// after the rising edge; outputs are compared 1 unit later.
// ---------------------------------------------------------------------------
module tb_pmem_arbiter;

   localparam int NREQ = 3;
   localparam int AW   = 9;
   localparam int DW   = 128;
`ifdef PMEM_ARB_AGE_EN
   localparam int AGE  = 2;
`else
   localparam int AGE  = 15;
`endif

   logic          clk;
   logic          reset;
   logic [DW-1:0] OP_q;
   logic [DW-1:0] OP_d;
   logic [AW-1:0] OP_addr;
   logic          OP_cen;
   logic          OP_wen;

   int errors = 0;
   int checks = 0;

   pmem_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

   pmem_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .AGE_LIMIT(AGE)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus.slave),
      .OP_q    (OP_q),
      .OP_d    (OP_d),
      .OP_addr (OP_addr),
      .OP_cen  (OP_cen),
      .OP_wen  (OP_wen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Unwritten words read back a pattern of their address; 0x012 -> 0xABAB..AB.
   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return {16{a[7:0] ^ 8'hB9}};
   endfunction

   logic [DW-1:0] mem    [512];
   bit            wr_vld [512];

   always @(posedge clk) begin
      if (!OP_cen) begin
         if (!OP_wen) begin
            mem[OP_addr]    <= OP_d;
            wr_vld[OP_addr] <= 1'b1;
         end else begin
            OP_q <= wr_vld[OP_addr] ? mem[OP_addr] : pat(OP_addr);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      bus.req       = '0;
      bus.req_we    = '0;
      bus.req_lock  = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
   endtask

   task automatic set_req(input int i, input bit we, input bit lk,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req[i]               = 1'b1;
      bus.req_we[i]            = we;
      bus.req_lock[i]          = lk;
      bus.req_addr[i*AW +: AW] = a;
      bus.req_wdata[i*DW +: DW] = d;
   endtask

   task automatic drop_req(input int i);
      bus.req[i]      = 1'b0;
      bus.req_lock[i] = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_reqs();
      #1;
      bus.req = 3'b111;
      #1;
      checks++; if (bus.gnt !== 3'b000) begin errors++; $display("FAIL rst_gnt: got %b want 000", bus.gnt); end
      checks++; if (OP_cen !== 1'b1 || OP_wen !== 1'b1) begin errors++; $display("FAIL rst_cen_wen: got %b%b want 11", OP_cen, OP_wen); end
      checks++; if (OP_addr !== '0 || OP_d !== '0) begin errors++; $display("FAIL rst_addr_d: got %h/%h want 0/0", OP_addr, OP_d); end
      cyc();
      checks++; if (bus.rvalid !== 3'b000) begin errors++; $display("FAIL rst_rvalid: got %b want 000", bus.rvalid); end
      clear_reqs();
      cyc();
      reset = 1'b0;
      #1;
      checks++; if (bus.gnt !== 3'b000 || OP_cen !== 1'b1) begin errors++; $display("FAIL rst_idle: gnt %b cen %b want 000 1", bus.gnt, OP_cen); end
      cyc();
   endtask

   task automatic test_single_read();
      set_req(2, 1'b0, 1'b0, 9'h012, '0);
      #1;
      checks++; if (bus.gnt !== 3'b100) begin errors++; $display("FAIL rd_gnt: got %b want 100", bus.gnt); end
      checks++; if (OP_cen !== 1'b0 || OP_wen !== 1'b1 || OP_addr !== 9'h012) begin
         errors++; $display("FAIL rd_pins: cen %b wen %b addr %h want 0 1 012", OP_cen, OP_wen, OP_addr); end
      cyc();
      clear_reqs();
      #1;
      checks++; if (bus.rvalid !== 3'b100) begin errors++; $display("FAIL rd_rvalid: got %b want 100", bus.rvalid); end
      checks++; if (bus.rdata !== {16{8'hAB}}) begin errors++; $display("FAIL rd_rdata: got %h want %h", bus.rdata, {16{8'hAB}}); end
      checks++; if (bus.gnt !== 3'b000 || OP_cen !== 1'b1) begin errors++; $display("FAIL rd_idle: gnt %b cen %b want 000 1", bus.gnt, OP_cen); end
      cyc();
   endtask

   // All three read continuously; grants rotate and rvalid trails by one cycle.
   task automatic test_round_robin();
      logic [2:0]    exp_g;
      logic [2:0]    prev_g;
      logic [AW-1:0] prev_a;
      for (int r = 0; r < NREQ; r++) set_req(r, 1'b0, 1'b0, AW'(9'h10 * (r + 1)), '0);
      prev_g = 3'b000;
      prev_a = '0;
      for (int i = 0; i < 6; i++) begin
         exp_g = 3'b001 << (i % 3);
         #1;
         checks++; if (bus.gnt !== exp_g || OP_addr !== AW'(9'h10 * (i % 3 + 1))) begin
            errors++; $display("FAIL rr_gnt[%0d]: got %b/%h want %b/%h", i, bus.gnt, OP_addr, exp_g, AW'(9'h10 * (i % 3 + 1))); end
         checks++; if (bus.rvalid !== prev_g) begin errors++; $display("FAIL rr_rvalid[%0d]: got %b want %b", i, bus.rvalid, prev_g); end
         if (i > 0) begin
            checks++; if (bus.rdata !== pat(prev_a)) begin errors++; $display("FAIL rr_rdata[%0d]: got %h want %h", i, bus.rdata, pat(prev_a)); end
         end
         prev_g = exp_g;
         prev_a = AW'(9'h10 * (i % 3 + 1));
         cyc();
      end
      clear_reqs();
      #1;
      checks++; if (bus.rvalid !== 3'b100 || bus.rdata !== pat(9'h030)) begin
         errors++; $display("FAIL rr_drain: got %b/%h want 100/%h", bus.rvalid, bus.rdata, pat(9'h030)); end
      cyc();
   endtask

   // ptr is parked at 1 first, so without the lock requester 0 would win B.
   task automatic test_lock();
      set_req(0, 1'b0, 1'b0, 9'h040, '0);
      #1;
      checks++; if (bus.gnt !== 3'b001) begin errors++; $display("FAIL lk_pre: got %b want 001", bus.gnt); end
      cyc();
      set_req(0, 1'b0, 1'b0, 9'h041, '0);
      set_req(1, 1'b0, 1'b1, 9'h005, '0);
      #1;
      checks++; if (bus.gnt !== 3'b010 || OP_wen !== 1'b1 || OP_addr !== 9'h005) begin
         errors++; $display("FAIL lk_read: gnt %b wen %b addr %h want 010 1 005", bus.gnt, OP_wen, OP_addr); end
      checks++; if (bus.rvalid !== 3'b001 || bus.rdata !== pat(9'h040)) begin
         errors++; $display("FAIL lk_rv0: got %b/%h want 001/%h", bus.rvalid, bus.rdata, pat(9'h040)); end
      cyc();
      set_req(1, 1'b1, 1'b1, 9'h005, 128'h1234_5678);
      #1;
      checks++; if (bus.gnt !== 3'b010 || OP_wen !== 1'b0 || OP_d !== 128'h1234_5678) begin
         errors++; $display("FAIL lk_write: gnt %b wen %b d %h want 010 0 12345678", bus.gnt, OP_wen, OP_d); end
      checks++; if (bus.rvalid !== 3'b010) begin errors++; $display("FAIL lk_rv1: got %b want 010", bus.rvalid); end
      cyc();
      drop_req(1);
      #1;
      checks++; if (bus.gnt !== 3'b001 || OP_addr !== 9'h041) begin
         errors++; $display("FAIL lk_release: gnt %b addr %h want 001 041", bus.gnt, OP_addr); end
      checks++; if (bus.rvalid !== 3'b000) begin errors++; $display("FAIL lk_wr_norv: got %b want 000", bus.rvalid); end
      cyc();
      clear_reqs();
      #1;
      checks++; if (bus.rvalid !== 3'b001 || bus.rdata !== pat(9'h041)) begin
         errors++; $display("FAIL lk_drain: got %b/%h want 001/%h", bus.rvalid, bus.rdata, pat(9'h041)); end
      cyc();
   endtask

   task automatic test_write_idle();
      set_req(0, 1'b1, 1'b0, 9'h1FF, 128'hDEAD);
      #1;
      checks++; if (bus.gnt !== 3'b001 || OP_cen !== 1'b0 || OP_wen !== 1'b0) begin
         errors++; $display("FAIL wr_ctl: gnt %b cen %b wen %b want 001 0 0", bus.gnt, OP_cen, OP_wen); end
      checks++; if (OP_addr !== 9'h1FF || OP_d !== 128'hDEAD) begin
         errors++; $display("FAIL wr_bus: addr %h d %h want 1ff dead", OP_addr, OP_d); end
      cyc();
      clear_reqs();
      #1;
      checks++; if (OP_cen !== 1'b1 || OP_wen !== 1'b1 || OP_addr !== '0 || OP_d !== '0) begin
         errors++; $display("FAIL wr_idle: cen %b wen %b addr %h d %h want 1 1 0 0", OP_cen, OP_wen, OP_addr, OP_d); end
      checks++; if (bus.rvalid !== 3'b000) begin errors++; $display("FAIL wr_norv: got %b want 000", bus.rvalid); end
      cyc();
   endtask

   // Reads back both words written above, from two different requesters.
   task automatic test_back_to_back();
      set_req(2, 1'b0, 1'b0, 9'h1FF, '0);
      #1;
      checks++; if (bus.gnt !== 3'b100) begin errors++; $display("FAIL bb_gnt0: got %b want 100", bus.gnt); end
      cyc();
      drop_req(2);
      set_req(1, 1'b0, 1'b0, 9'h005, '0);
      #1;
      checks++; if (bus.gnt !== 3'b010) begin errors++; $display("FAIL bb_gnt1: got %b want 010", bus.gnt); end
      checks++; if (bus.rvalid !== 3'b100 || bus.rdata !== 128'hDEAD) begin
         errors++; $display("FAIL bb_rv0: got %b/%h want 100/dead", bus.rvalid, bus.rdata); end
      cyc();
      clear_reqs();
      #1;
      checks++; if (bus.rvalid !== 3'b010 || bus.rdata !== 128'h1234_5678) begin
         errors++; $display("FAIL bb_rv1: got %b/%h want 010/12345678", bus.rvalid, bus.rdata); end
      cyc();
   endtask

   task automatic test_reset_mid();
      set_req(0, 1'b0, 1'b0, 9'h066, '0);
      #1;
      checks++; if (bus.gnt !== 3'b001) begin errors++; $display("FAIL rm_pre: got %b want 001", bus.gnt); end
      cyc();
      clear_reqs();
      set_req(1, 1'b0, 1'b0, 9'h077, '0);
      #1;
      checks++; if (bus.gnt !== 3'b010) begin errors++; $display("FAIL rm_gnt: got %b want 010", bus.gnt); end
      reset = 1'b1;
      #1;
      checks++; if (bus.gnt !== 3'b000 || OP_cen !== 1'b1 || bus.rvalid !== 3'b000) begin
         errors++; $display("FAIL rm_assert: gnt %b cen %b rv %b want 000 1 000", bus.gnt, OP_cen, bus.rvalid); end
      cyc();
      checks++; if (bus.rvalid !== 3'b000 || OP_addr !== '0 || OP_wen !== 1'b1) begin
         errors++; $display("FAIL rm_flush: rv %b addr %h wen %b want 000 0 1", bus.rvalid, OP_addr, OP_wen); end
      clear_reqs();
      reset = 1'b0;
      for (int r = 0; r < NREQ; r++) set_req(r, 1'b0, 1'b0, AW'(9'h080 + r), '0);
      #1;
      checks++; if (bus.gnt !== 3'b001) begin errors++; $display("FAIL rm_first: got %b want 001", bus.gnt); end
      cyc();
      #1;
      checks++; if (bus.rvalid !== 3'b001 || bus.gnt !== 3'b010) begin
         errors++; $display("FAIL rm_next: rv %b gnt %b want 001 010", bus.rvalid, bus.gnt); end
      clear_reqs();
      cyc();
      cyc();
   endtask

`ifdef PMEM_ARB_AGE_EN
   task automatic test_age();
      bit got;
      got = 1'b0;
      set_req(0, 1'b0, 1'b0, 9'h100, '0);
      set_req(1, 1'b0, 1'b0, 9'h101, '0);
      set_req(2, 1'b0, 1'b0, 9'h102, '0);
      for (int i = 0; i < 3; i++) begin
         #1;
         if (bus.gnt[2]) got = 1'b1;
         cyc();
      end
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL age_grant: got %b want 1", got); end
      clear_reqs();
      cyc();
   endtask
`endif

   initial begin
      clear_reqs();
      test_reset();
      test_single_read();
      test_round_robin();
      test_lock();
      test_write_idle();
      test_back_to_back();
      test_reset_mid();
`ifdef PMEM_ARB_AGE_EN
      test_age();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, want finish before 100000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
Arbitrates the single-port PMEM/output SRAM (128-bit, 9-bit address, active-low cen/wen) between NREQ requesters: OFIFO psum writeback (0), SFU accumulate read-modify-write (1), and host/testbench readout (2). It selects one access per cycle by round-robin, supports a lock for read-then-write pairs, and routes the 1-cycle-delayed read data back to the requester that issued the read. It sits between corelet's datapath clients and the OP_* SRAM pins.

Parameters:
NREQ, 3, number of requesters (2..8)
ADDR_W, 9, SRAM address width
DATA_W, 128, SRAM data width (col*psum_bw)
RD_LAT, 1, SRAM read latency in cycles (>=1)
AGE_LIMIT, 15, wait cycles before age promotion (used only with PMEM_ARB_AGE_EN)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high
req  input  NREQ  access request per requester
req_we  input  NREQ  1 = write, 0 = read
req_lock  input  NREQ  hold grant on the following cycle (RMW)
req_addr  input  NREQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
req_wdata  input  NREQ*DATA_W  packed write data
gnt  output  NREQ  one-hot grant; the access is performed this cycle
rvalid  output  NREQ  one-hot read-data-valid, RD_LAT cycles after the read grant
rdata  output  DATA_W  read data (pass-through of OP_q)
OP_q  input  DATA_W  SRAM read data
OP_d  output  DATA_W  SRAM write data
OP_addr  output  ADDR_W  SRAM address
OP_cen  output  1  SRAM chip enable, active-low
OP_wen  output  1  SRAM write enable, active-low

Behaviour:
- Reset values: gnt=0, rvalid=0, OP_cen=1, OP_wen=1, OP_addr=0, OP_d=0. The rr pointer resets to 0, lock owner is none, and the read-tag pipeline is cleared. gnt is forced to 0 while reset is high.
- Grant is combinational from req in the same cycle. The winner's addr, wdata and we drive OP_addr, OP_d and OP_wen=~we, with OP_cen=0. The SRAM samples at the next posedge.
- No request: OP_cen=1, OP_wen=1, OP_addr=0, OP_d=0, gnt=0. The pointer does not move.
- Round-robin: search starts at ptr. After a grant to requester k, ptr <= (k+1) mod NREQ.
- Lock: if the requester granted in cycle t has req_lock=1 and still asserts req in t+1, it wins t+1 regardless of ptr. This repeats while req and req_lock stay high. Dropping either signal releases the lock. The pointer still advances past the lock owner.
- A requester whose req drops while it is not granted loses nothing. gnt is never asserted without req.
- Read return: when a read is granted, the requester id enters a RD_LAT-deep tag shift register. rvalid[id] rises exactly RD_LAT cycles later for one cycle. rdata=OP_q at all times. Writes create no tag and no rvalid.
- Back-to-back reads from different requesters produce back-to-back rvalid pulses in grant order. Throughput is 1 access/cycle.
- Requesters must hold req, addr, wdata and we stable until gnt. Requesters must accept rvalid unconditionally (no backpressure).
- Reset mid-operation: the tag pipeline is flushed, so in-flight reads produce no rvalid.
- Out-of-range ptr cannot occur; when NREQ is not a power of 2, the wrap is explicit.

Optional Feature:
PMEM_ARB_AGE_EN
- Defined: each requester has a wait counter (width clog2(AGE_LIMIT+1)). It increments each cycle req=1 and not granted, and clears on grant or when req=0. A requester whose counter is >= AGE_LIMIT wins over round-robin (lowest index among aged requesters), but not over an active lock. Counters reset to 0.
- Undefined: no counters; pure round-robin plus lock.

Decomposition:
- Package pmem_arb_pkg holds:
  - requester index constants REQ_OFIFO=0, REQ_SFU=1, REQ_HOST=2
  - default widths PMEM_ADDR_W=9, PMEM_DATA_W=128
  - a function rr_pick(req, ptr) returning a one-hot grant
- Sub-module rr_arbiter (NREQ): req and ptr in, one-hot gnt and the encoded index out; purely combinational.
- The top level owns ptr, lock, the tag pipeline and the age counters.

Test Plan:
- Single read: req=3'b100, we=0, addr=9'h012, SRAM word 0x...AB → gnt=3'b100 same cycle; OP_cen=0, OP_wen=1, OP_addr=0x012; next cycle rvalid=3'b100, rdata=0x...AB.
- All three requesting reads continuously → gnt sequence 001, 010, 100, 001…; rvalid sequence lags gnt by 1 cycle.
- RMW lock: req[1] with lock=1 for 2 cycles (read then write addr 5), req[0] also high → gnt[1] on both cycles, then gnt[0]; OP_wen = 1 then 0.
- Idle/mixed: write from req0 with data 0xDEAD at addr 0x1FF → OP_wen=0, OP_d=0xDEAD, no rvalid; next idle cycle OP_cen=1.
- Reset asserted the cycle after a read grant → rvalid stays 0, outputs return to reset values, and the first grant after reset goes to requester 0.
- With PMEM_ARB_AGE_EN and AGE_LIMIT=2, requester 2 starved by a lock-free 0/1 pattern → requester 2 is granted no later than 3 cycles after first asserting req.
